// File: rtl/mult_unit.sv
`timescale 1ns/1ps
// Iterative shift-add multiplier (signed/unsigned) for the MULT instruction.
// Latency: start edge -> WIDTH busy cycles -> done with valid hi/lo in cycle WIDTH+1.
// No backpressure: start is ignored while busy; a start held through DONE chains the next op.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Accumulator: upper half collects partial sums, lower half starts as the
    // multiplier and is consumed one bit per iteration from the bottom.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] result;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == RUN) && (cnt == '0);

    // Operand magnitudes; negating the most-negative value wraps back to
    // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[WIDTH-1]) begin
            a_mag = -a;
        end
        if (is_signed && b[WIDTH-1]) begin
            b_mag = -b;
        end
    end

    // One shift-add iteration: conditional add into the upper half with the
    // carry kept, then the whole accumulator shifts right so the carry lands
    // in the top bit.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // Sign fix-up of the final magnitude product.
    always_comb begin
        result = acc_nxt;
        if (neg) begin
            result = -acc_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles, DONE lasts one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decode the registered state only, so inputs never reach
    // outputs combinationally.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, publish the product on the
    // edge that enters DONE; hi/lo hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            acc   <= {{WIDTH{1'b0}}, b_mag};
            mcand <= a_mag;
            cnt   <= CW'(WIDTH - 1);
            neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (last_iter) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end
        end
    end

endmodule
